// File: rtl/fetch_pkg.sv
// Shared types and constants for the picoMIPS fetch stage.
package fetch_pkg;

    localparam int OPC_W = 6;

    // All-zero word decodes as the NOP opcode; sliced to ISIZE by the user.
    localparam logic [63:0] NOP_WORD = '0;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/sw8_stepper.sv
// Single-step gate for the board switch: synchronise SW8, detect rising edges,
// and hold a token that allows exactly one instruction to retire per press.
module sw8_stepper (
    input  logic clk,
    input  logic reset,
    input  logic sw8,
    input  logic retire,
    output logic step_token
);

    logic sync1;
    logic sync2;
    logic sync_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            sync_prev  <= 1'b0;
            step_token <= 1'b0;
        end else begin
            sync1     <= sw8;
            sync2     <= sync1;
            sync_prev <= sync2;
            // A fresh press wins over a retire landing in the same cycle.
            if (sync2 && !sync_prev) begin
                step_token <= 1'b1;
            end else if (retire) begin
                step_token <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// picoMIPS instruction fetch: PC ownership, synchronous ROM addressing, branch squash, hold.
// Optional single-step from board switch SW8 when FETCH_SW8_STEP_EN is defined.
// Decoder handshake: controls are consumed only in a cycle where instr_valid=1; one of them must be set then.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int PSIZE = 5,
    parameter int ISIZE = 18
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               PCincr,
    input  logic               PCabsbranch,
    input  logic               PCrelbranch,
    input  logic [PSIZE-1:0]   branch_addr,
    input  logic               hold,
`ifdef FETCH_SW8_STEP_EN
    input  logic               SW8,
`endif
    output logic [PSIZE-1:0]   rom_addr,
    input  logic [ISIZE-1:0]   rom_data,
    output logic [ISIZE-1:0]   instr,
    output logic [OPC_W-1:0]   opcode,
    output logic               instr_valid,
    output logic [PSIZE-1:0]   pc_out,
    output fetch_state_t       dbg_state
);

    fetch_state_t     state;
    fetch_state_t     state_nxt;
    logic [PSIZE-1:0] fetch_pc;
    logic [PSIZE-1:0] exec_pc;
    logic [PSIZE-1:0] fetch_nxt;
    logic [PSIZE-1:0] exec_nxt;
    logic             hold_eff;
    logic             run_live;

`ifdef FETCH_SW8_STEP_EN
    logic step_token;

    sw8_stepper u_stepper (
        .clk        (clk),
        .reset      (reset),
        .sw8        (SW8),
        .retire     (run_live),
        .step_token (step_token)
    );

    assign hold_eff = hold | ~step_token;
`else
    assign hold_eff = hold;
`endif

    assign run_live  = (state == RUN) && !hold_eff;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FILL;
            fetch_pc <= '0;
            exec_pc  <= '0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_nxt;
            exec_pc  <= exec_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        fetch_nxt   = fetch_pc;
        exec_nxt    = exec_pc;
        rom_addr    = fetch_pc;
        instr_valid = 1'b0;
        instr       = NOP_WORD[ISIZE-1:0];
        opcode      = '0;
        pc_out      = exec_pc;
        case (state)
            FILL: begin
                fetch_nxt = fetch_pc + PSIZE'(1);
                exec_nxt  = '0;
                state_nxt = RUN;
            end
            RUN: begin
                if (hold_eff) begin
                    // Re-read the current word so it is on rom_data at release.
                    rom_addr = exec_pc;
                end else if (PCabsbranch) begin
                    fetch_nxt = branch_addr;
                    state_nxt = FLUSH;
                end else if (PCrelbranch) begin
                    fetch_nxt = exec_pc + branch_addr;
                    state_nxt = FLUSH;
                end else begin
                    exec_nxt  = fetch_pc;
                    fetch_nxt = fetch_pc + PSIZE'(1);
                end
            end
            FLUSH: begin
                exec_nxt  = fetch_pc;
                fetch_nxt = fetch_pc + PSIZE'(1);
                state_nxt = RUN;
            end
            default: begin
                state_nxt = FILL;
            end
        endcase
        if (run_live) begin
            instr_valid = 1'b1;
            instr       = rom_data;
            opcode      = rom_data[ISIZE-1 -: OPC_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && run_live) begin
            assert (!(PCabsbranch && PCrelbranch) && (PCabsbranch || PCrelbranch || PCincr));
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit (default build): reset, sequential wrap, abs/rel branches,
// hold, hold ignored in FLUSH, and reset during FLUSH.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int PSIZE = 5;
    localparam int ISIZE = 18;

    logic               clk;
    logic               reset;
    logic               PCincr;
    logic               PCabsbranch;
    logic               PCrelbranch;
    logic [PSIZE-1:0]   branch_addr;
    logic               hold;
    logic [PSIZE-1:0]   rom_addr;
    logic [ISIZE-1:0]   rom_data;
    logic [ISIZE-1:0]   instr;
    logic [5:0]         opcode;
    logic               instr_valid;
    logic [PSIZE-1:0]   pc_out;
    fetch_state_t       dbg_state;

    logic [ISIZE-1:0]   mem [32];

    int checks;
    int errors;

    fetch_unit #(.PSIZE(PSIZE), .ISIZE(ISIZE)) dut (
        .clk         (clk),
        .reset       (reset),
        .PCincr      (PCincr),
        .PCabsbranch (PCabsbranch),
        .PCrelbranch (PCrelbranch),
        .branch_addr (branch_addr),
        .hold        (hold),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .instr       (instr),
        .opcode      (opcode),
        .instr_valid (instr_valid),
        .pc_out      (pc_out),
        .dbg_state   (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous program ROM: data for rom_addr appears after the next edge.
    always @(posedge clk) rom_data <= mem[rom_addr];

    // Opcode field = i+1 so opcode extraction is exercised, low bits = 7*i.
    function automatic logic [ISIZE-1:0] word(input int i);
        logic [5:0]  op;
        logic [11:0] lo;
        op = 6'(i + 1);
        lo = 12'(i * 7);
        return {op, lo};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bubble(input string tag, input int addr);
        chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
        chk({tag, "_instr"}, 32'(instr), 32'd0);
        chk({tag, "_opcode"}, 32'(opcode), 32'd0);
        chk({tag, "_rom_addr"}, 32'(rom_addr), 32'(addr));
    endtask

    task automatic chk_run(input string tag, input int pc, input int next_addr);
        logic [ISIZE-1:0] w;
        w = word(pc);
        chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
        chk({tag, "_pc"}, 32'(pc_out), 32'(pc));
        chk({tag, "_instr"}, 32'(instr), 32'(w));
        chk({tag, "_opcode"}, 32'(opcode), 32'(w[ISIZE-1 -: 6]));
        chk({tag, "_rom_addr"}, 32'(rom_addr), 32'(next_addr));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 32; i++) mem[i] = word(i);

        reset       = 1'b1;
        PCincr      = 1'b1;
        PCabsbranch = 1'b0;
        PCrelbranch = 1'b0;
        branch_addr = '0;
        hold        = 1'b0;

        // Reset state
        tick();
        tick();
        chk_bubble("rst", 0);
        chk("rst_pc", 32'(pc_out), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(FILL));

        // First cycle after release is FILL, then mem[0], mem[1]
        reset = 1'b0;
        #1;
        chk_bubble("fill", 0);
        tick();
        chk_run("seq0", 0, 1);
        tick();
        chk_run("seq1", 1, 2);

        // Relative branch -2 at pc 1 wraps to 31
        PCrelbranch = 1'b1;
        branch_addr = 5'b11110;
        tick();
        PCrelbranch = 1'b0;
        #1;
        chk_bubble("rel_flush", 31);
        chk("rel_flush_state", 32'(dbg_state), 32'(FLUSH));
        tick();
        chk_run("rel_tgt", 31, 0);
        for (int p = 0; p <= 3; p++) begin
            tick();
            chk_run("rel_seq", p, p + 1);
        end

        // Absolute branch to 20 at pc 3, then run sequentially through 31 -> 0 up to 7
        PCabsbranch = 1'b1;
        branch_addr = 5'd20;
        tick();
        PCabsbranch = 1'b0;
        #1;
        chk_bubble("abs_flush", 20);
        tick();
        chk_run("abs_tgt", 20, 21);
        for (int k = 1; k <= 19; k++) begin
            tick();
            chk_run("wrap_seq", (20 + k) % 32, (21 + k) % 32);
        end

        // Hold for 3 cycles at pc 7
        hold = 1'b1;
        #1;
        chk_bubble("hold0", 7);
        chk("hold0_pc", 32'(pc_out), 32'd7);
        tick();
        chk_bubble("hold1", 7);
        tick();
        chk_bubble("hold2", 7);
        chk("hold2_pc", 32'(pc_out), 32'd7);
        hold = 1'b0;
        #1;
        chk_run("hold_rel", 7, 8);
        tick();
        chk_run("hold_next", 8, 9);

        // Abs beats incr; hold during FLUSH is ignored, then holds in RUN
        PCabsbranch = 1'b1;
        branch_addr = 5'd28;
        tick();
        PCabsbranch = 1'b0;
        hold        = 1'b1;
        #1;
        chk_bubble("flush_hold", 28);
        chk("flush_hold_state", 32'(dbg_state), 32'(FLUSH));
        tick();
        chk_bubble("run_hold", 28);
        chk("run_hold_state", 32'(dbg_state), 32'(RUN));
        hold = 1'b0;
        #1;
        chk_run("abs28", 28, 29);

        // Relative +5 from 28 wraps up to 1
        PCrelbranch = 1'b1;
        branch_addr = 5'd5;
        tick();
        PCrelbranch = 1'b0;
        #1;
        chk_bubble("relp_flush", 1);
        tick();
        chk_run("relp_tgt", 1, 2);

        // Reset while in FLUSH discards the pending target
        PCabsbranch = 1'b1;
        branch_addr = 5'd12;
        tick();
        PCabsbranch = 1'b0;
        reset       = 1'b1;
        #1;
        chk_bubble("rstfl_pre", 12);
        tick();
        chk_bubble("rstfl", 0);
        chk("rstfl_pc", 32'(pc_out), 32'd0);
        chk("rstfl_state", 32'(dbg_state), 32'(FILL));
        reset = 1'b0;
        tick();
        chk_run("rstfl_run0", 0, 1);
        tick();
        chk_run("rstfl_run1", 1, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
